// File: rtl/mux_4_1_pkg.sv
// Shared constants and types for the sliced 4:1 multiplexer.
// Optional simulation checks are enabled with MUX_4_1_ASSERT_EN.
package mux_4_1_pkg;

  localparam int DEF_WIDTH    = 4;
  localparam int DEF_NARROW_W = 2;

  typedef logic [1:0] sel_t;

  localparam sel_t SEL_D0 = 2'd0;
  localparam sel_t SEL_D1 = 2'd1;
  localparam sel_t SEL_D2 = 2'd2;
  localparam sel_t SEL_D3 = 2'd3;

  // Number of slice muxes needed to cover a full data word.
  function automatic int num_slices(input int width, input int narrow_w);
    return width / narrow_w;
  endfunction

endpackage

// File: rtl/mux_4_1_narrow.sv
// Narrow 4:1 slice mux; an unknown select drives all-X instead of picking an input.
// Optional elaboration check is enabled with MUX_4_1_ASSERT_EN.
module mux_4_1_narrow
  import mux_4_1_pkg::*;
#(
  parameter int NARROW_W = DEF_NARROW_W
) (
  input  logic [NARROW_W-1:0] d0,
  input  logic [NARROW_W-1:0] d1,
  input  logic [NARROW_W-1:0] d2,
  input  logic [NARROW_W-1:0] d3,
  input  sel_t                sel,
  output logic [NARROW_W-1:0] y
);

  always_comb begin
    case (sel)
      SEL_D0:  y = d0;
      SEL_D1:  y = d1;
      SEL_D2:  y = d2;
      SEL_D3:  y = d3;
      default: y = 'x;
    endcase
  end

`ifdef MUX_4_1_ASSERT_EN
  if (NARROW_W <= 0) begin : g_bad_narrow_w
    $fatal(1, "mux_4_1_narrow: NARROW_W must be positive, got %0d", NARROW_W);
  end
`endif

endmodule

// File: rtl/mux_4_1.sv
// WIDTH-bit 4:1 multiplexer built from NARROW_W-bit slices, with a registered copy y_q.
// Define MUX_4_1_ASSERT_EN to compile simulation-only configuration and select checks.
module mux_4_1
  import mux_4_1_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int NARROW_W = DEF_NARROW_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  input  logic [1:0]       sel,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_q
);

  localparam int NSLICE = num_slices(WIDTH, NARROW_W);

  // Each slice routes the same bit range of all four inputs on the shared select.
  for (genvar gi = 0; gi < NSLICE; gi++) begin : g_slice
    mux_4_1_narrow #(
      .NARROW_W(NARROW_W)
    ) u_slice (
      .d0  (d0[gi*NARROW_W +: NARROW_W]),
      .d1  (d1[gi*NARROW_W +: NARROW_W]),
      .d2  (d2[gi*NARROW_W +: NARROW_W]),
      .d3  (d3[gi*NARROW_W +: NARROW_W]),
      .sel (sel),
      .y   (y[gi*NARROW_W +: NARROW_W])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q <= '0;
    end else begin
      y_q <= y;
    end
  end

`ifdef MUX_4_1_ASSERT_EN
  if (WIDTH <= 0 || (WIDTH % NARROW_W) != 0) begin : g_bad_cfg
    $fatal(1, "mux_4_1: WIDTH (%0d) must be a positive multiple of NARROW_W (%0d)",
           WIDTH, NARROW_W);
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!$isunknown(sel))
        else $error("mux_4_1: sel contains X/Z: %b", sel);
    end
  end
`endif

endmodule

// File: tb/tb_mux_4_1.sv
// Randomized and directed bench for mux_4_1 against an array-lookup reference model.
module tb_mux_4_1;

  localparam int W  = 4;
  localparam int W8 = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [W-1:0]  d0, d1, d2, d3, y, y_q;
  logic [1:0]    sel;
  logic [W8-1:0] e0, e1, e2, e3, y8, y8_q;
  logic [1:0]    sel8;

  int   tests = 0;
  int   fails = 0;
  logic chk_en = 1'b0;
  logic four_state;
  logic probe;
  logic [W-1:0]  exp_q;
  logic [W8-1:0] exp8_q;
  logic [W-1:0]  rot_exp [4];

  always #5 clk = ~clk;

  mux_4_1 #(.WIDTH(W), .NARROW_W(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .d0(d0), .d1(d1), .d2(d2), .d3(d3),
    .sel(sel), .y(y), .y_q(y_q)
  );

  mux_4_1 #(.WIDTH(W8), .NARROW_W(2)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .d0(e0), .d1(e1), .d2(e2), .d3(e3),
    .sel(sel8), .y(y8), .y_q(y8_q)
  );

  // Reference: pick the input whose index equals sel.
  function automatic logic [W-1:0] ref4(input logic [1:0] s,
                                        input logic [W-1:0] a, b, c, dd);
    logic [W-1:0] arr [4];
    arr = '{a, b, c, dd};
    return arr[s];
  endfunction

  function automatic logic [W8-1:0] ref8(input logic [1:0] s,
                                         input logic [W8-1:0] a, b, c, dd);
    logic [W8-1:0] arr [4];
    arr = '{a, b, c, dd};
    return arr[s];
  endfunction

  task automatic check(input string name, input logic [W8-1:0] act, input logic [W8-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected register contents: cleared at once by reset, else last edge's selection.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q  <= '0;
      exp8_q <= '0;
    end else begin
      exp_q  <= ref4(sel, d0, d1, d2, d3);
      exp8_q <= ref8(sel8, e0, e1, e2, e3);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cmp_y",    {4'h0, y},   {4'h0, ref4(sel, d0, d1, d2, d3)});
      check("cmp_y_q",  {4'h0, y_q}, {4'h0, exp_q});
      check("cmp_y8",   y8,   ref8(sel8, e0, e1, e2, e3));
      check("cmp_y8_q", y8_q, exp8_q);
      $display("[TB] t=%0t rst_n=%b sel=%0d y=%h y_q=%h sel8=%0d y8=%h y8_q=%h",
               $time, rst_n, sel, y, y_q, sel8, y8, y8_q);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    probe = 1'bx;
    four_state = $isunknown(probe);
    rot_exp = '{4'ha, 4'hb, 4'hc, 4'hd};
    rst_n = 1'b1;
    {d0, d1, d2, d3} = '0;
    {e0, e1, e2, e3} = '0;
    sel = 2'd0;
    sel8 = 2'd0;

    #1 rst_n = 1'b0;
    #1;
    check("reset_y_q",  {4'h0, y_q}, 8'h00);
    check("reset_y8_q", y8_q, 8'h00);
    step();
    rst_n = 1'b1;
    chk_en = 1'b1;

    // Rotate the select over fixed inputs.
    d0 = 4'ha; d1 = 4'hb; d2 = 4'hc; d3 = 4'hd;
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      #1;
      check("rotate_y", {4'h0, y}, {4'h0, rot_exp[s]});
      $display("[TB] rotate sel=%0d y=%h", sel, y);
    end

    // Unknown on an unselected input must not leak into y.
    step();
    d0 = 4'd7; d1 = 4'd10; d2 = 4'd3; d3 = 'x;
    sel = 2'd0; #1 check("xin_sel0", {4'h0, y}, 8'h07);
    sel = 2'd1; #1 check("xin_sel1", {4'h0, y}, 8'h0a);
    sel = 2'd2; #1 check("xin_sel2", {4'h0, y}, 8'h03);
    if (four_state) begin
      sel = 2'd3; #1 check("xin_sel3", {4'h0, y}, {4'h0, 4'bxxxx});
      sel = 2'bx; #1 check("xsel",     {4'h0, y}, {4'h0, 4'bxxxx});
    end
    $display("[TB] x-propagation checks done (four_state=%b)", four_state);
    step();
    sel = 2'd0; d3 = 4'hd;

    // Both slices route independently.
    step();
    d0 = 4'h5; d1 = 4'ha; d2 = 4'h3; d3 = 4'hc; sel = 2'd1;
    e0 = 8'h11; e1 = 8'h22; e2 = 8'ha5; e3 = 8'h33; sel8 = 2'd2;
    #1;
    check("slice_y",  {4'h0, y}, 8'h0a);
    check("slice_y8", y8, 8'ha5);
    sel8 = 2'd0; #1 check("slice_y8_d0", y8, 8'h11);
    $display("[TB] slice y=%h y8=%h", y, y8);

    // Asynchronous reset and first capture after release.
    step();
    sel = 2'd3; d3 = 4'hd;
    step();
    #1 rst_n = 1'b0;
    #1;
    check("rst_async_y_q", {4'h0, y_q}, 8'h00);
    check("rst_async_y",   {4'h0, y},   8'h0d);
    step();
    check("rst_hold_y_q",  {4'h0, y_q}, 8'h00);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_release_y_q", {4'h0, y_q}, 8'h0d);
    $display("[TB] reset release y_q=%h", y_q);

    // y follows sel immediately; y_q waits for the next edge.
    d0 = 4'ha; d1 = 4'hb; d2 = 4'hc; d3 = 4'hd; sel = 2'd0;
    @(posedge clk); #1;
    check("lat_y_q_old", {4'h0, y_q}, 8'h0a);
    #2 sel = 2'd2;
    #1;
    check("lat_y_now",   {4'h0, y},   8'h0c);
    check("lat_y_q_hold", {4'h0, y_q}, 8'h0a);
    @(posedge clk); #1;
    check("lat_y_q_new", {4'h0, y_q}, 8'h0c);
    $display("[TB] latency y=%h y_q=%h", y, y_q);

    // Random traffic with occasional mid-cycle reset pulses.
    for (int i = 0; i < 300; i++) begin
      step();
      d0 = 4'($urandom); d1 = 4'($urandom); d2 = 4'($urandom); d3 = 4'($urandom);
      e0 = 8'($urandom); e1 = 8'($urandom); e2 = 8'($urandom); e3 = 8'($urandom);
      sel = 2'($urandom_range(0, 3));
      sel8 = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) begin
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
    end

    step();
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
